// File: rtl/inst_fetch_queue.sv
// Show-ahead instruction queue between the I-cache and the decoder.
// The head entry is presented combinationally; fetch is stalled with slack before the queue fills.
module inst_fetch_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 3,
  parameter int STALL_SLACK = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic                  o_overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] STALL_CNT = (DEPTH_LOG2+1)'(DEPTH - STALL_SLACK);

  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;
  logic                  overflow_q, overflow_d;

  logic full;
  logic pop;
  logic push;

  assign full = (count_q == FULL_CNT);
  assign pop  = o_valid & i_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = i_valid & (~full | pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (i_valid && full && !pop) begin
      overflow_d = 1'b1;
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
        2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset: contents are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      addr_mem_q[wr_ptr_q] <= i_addr;
      data_mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_valid    = (count_q != '0);
  assign o_stall    = (count_q >= STALL_CNT);
  assign o_addr     = addr_mem_q[rd_ptr_q];
  assign o_data     = data_mem_q[rd_ptr_q];
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DL    = 3;
  localparam int SL    = 2;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          i_valid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic          o_stall;
  logic          o_valid;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          i_ready;
  logic          o_overflow;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  int   checks = 0;
  int   errors = 0;

  inst_fetch_queue #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_LOG2 (DL),
    .STALL_SLACK(SL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .o_stall   (o_stall),
    .o_valid   (o_valid),
    .o_addr    (o_addr),
    .o_data    (o_data),
    .i_ready   (i_ready),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit r, input bit f);
    bit m_pop;
    bit m_push;
    i_valid = v;
    i_addr  = a;
    i_data  = d;
    i_ready = r;
    flush   = f;
    @(negedge clk);
    check_val("valid", 64'(o_valid), 64'(mq.size() != 0));
    check_val("stall", 64'(o_stall), 64'(mq.size() >= DEPTH - SL));
    check_val("overflow", 64'(o_overflow), 64'(m_ovf));
    if (mq.size() != 0) begin
      check_val("head_addr", 64'(o_addr), 64'(mq[0].a));
      check_val("head_data", 64'(o_data), 64'(mq[0].d));
    end
    m_pop  = (mq.size() != 0) && r;
    m_push = v && ((mq.size() < DEPTH) || m_pop);
    if (v && mq.size() == DEPTH && !m_pop) m_ovf = 1'b1;
    if (f) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{a: a, d: d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain_all();
    for (int k = 0; k < 4 * DEPTH && mq.size() != 0; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom,
           $urandom_range(0, 9) < 5, $urandom_range(0, 39) == 0);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_addr = '0; i_data = '0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(o_valid), 64'(0));
    check_val("rst_stall", 64'(o_stall), 64'(0));
    check_val("rst_ovf", 64'(o_overflow), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single push, hold, then pop.
    step(1'b1, 32'h100, 32'h0000_0013, 1'b0, 1'b0);
    check_val("single_valid", 64'(o_valid), 64'(1));
    check_val("single_addr", 64'(o_addr), 64'h100);
    check_val("single_data", 64'(o_data), 64'h13);
    idle(3);
    check_val("hold_addr", 64'(o_addr), 64'h100);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_val("popped_valid", 64'(o_valid), 64'(0));

    // Fill to the stall point, to full, then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 1'b0);
      if (i == DEPTH - SL - 1) check_val("stall_at_6", 64'(o_stall), 64'(1));
      if (i == DEPTH - SL - 2) check_val("nostall_at_5", 64'(o_stall), 64'(0));
    end
    step(1'b1, 32'h200, 32'hDEAD, 1'b0, 1'b0);
    check_val("ovf_set", 64'(o_overflow), 64'(1));
    for (int i = 0; i < DEPTH; i++) begin
      check_val("drain_addr", 64'(o_addr), 64'(32'h100 + 32'(4 * i)));
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
    check_val("drained_valid", 64'(o_valid), 64'(0));
    check_val("ovf_sticky", 64'(o_overflow), 64'(1));

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h300 + 32'(4 * i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h400, 32'h4444, 1'b1, 1'b0);
    check_val("full_pp_stall", 64'(o_stall), 64'(1));
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    check_val("last_addr", 64'(o_addr), 64'h400);
    check_val("last_data", 64'(o_data), 64'h4444);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with a concurrent push.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + 32'(4 * i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h5FC, 32'h5555, 1'b0, 1'b1);
    check_val("flush_valid", 64'(o_valid), 64'(0));
    idle(2);

    // Streaming through the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h600 + 32'(4 * i), 32'h6000 + 32'(i), 1'b1, 1'b0);
      check_val("stream_addr", 64'(o_addr), 64'(32'h600 + 32'(4 * i)));
      check_val("stream_stall", 64'(o_stall), 64'(0));
    end
    drain_all();

    random_phase(400);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    i_valid = 1'b0;
    #1;
    check_val("async_rst_valid", 64'(o_valid), 64'(0));
    check_val("async_rst_stall", 64'(o_stall), 64'(0));
    check_val("async_rst_ovf", 64'(o_overflow), 64'(0));
    mq.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    random_phase(400);
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
